// File: rtl/note_sequencer.sv
// note_sequencer: steps through a small pattern memory of {dur, note} entries
// at a programmable tempo and offers each note code to the tone generator over
// a valid/ready handshake.
// Optional feature macro: MUSIC_SEQ_LOOP_EN (adds loop_i; the pattern repeats
// until stop instead of ending through FINISH).
module note_sequencer #(
  parameter int unsigned STEPS  = 16,
  parameter int unsigned NOTE_W = 6,
  parameter int unsigned DUR_W  = 2,
  parameter int unsigned TICK_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(STEPS)-1:0]   wr_addr,
  input  logic [DUR_W+NOTE_W-1:0]    wr_data,
  input  logic [$clog2(STEPS)-1:0]   len_i,
  input  logic [TICK_W-1:0]          tempo_i,
  input  logic                       start,
  input  logic                       stop,
`ifdef MUSIC_SEQ_LOOP_EN
  input  logic                       loop_i,
`endif
  output logic                       note_valid,
  output logic [NOTE_W-1:0]          note_code,
  input  logic                       note_ready,
  output logic                       busy,
  output logic [$clog2(STEPS)-1:0]   step_idx,
  output logic                       done
);

  localparam int unsigned IDX_W = $clog2(STEPS);
  localparam int unsigned ENT_W = DUR_W + NOTE_W;

  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_HOLD   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;

  logic [ENT_W-1:0]  r_mem [STEPS];
  logic [ENT_W-1:0]  w_entry;

  logic [IDX_W-1:0]  r_len;
  logic [IDX_W-1:0]  r_step;
  logic [TICK_W-1:0] r_tempo;
  logic [TICK_W-1:0] r_presc;
  logic [DUR_W-1:0]  r_dur;
  logic [DUR_W-1:0]  r_beat;
  logic [NOTE_W-1:0] r_note;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_beat;
  logic              w_note_end;
  logic              w_last;
  logic              w_loop;

  assign w_entry    = r_mem[r_step];
  assign w_accept   = (r_state == S_IDLE) && start && !stop;
  assign w_beat     = (r_presc == r_tempo);
  assign w_note_end = (r_state == S_HOLD) && w_beat && (r_beat == r_dur);
  // len 0 wraps to all-ones, which is exactly STEPS-1
  assign w_last     = (r_step == IDX_W'(r_len - IDX_ONE));

`ifdef MUSIC_SEQ_LOOP_EN
  logic r_loop;

  // Loop mode is sampled once per playback, alongside length and tempo
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loop <= 1'b0;
    end else if (w_accept) begin
      r_loop <= loop_i;
    end
  end

  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic; stop overrides every non-idle transition
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nx = S_FETCH;
      S_FETCH:  w_state_nx = S_ISSUE;
      S_ISSUE:  if (r_valid && note_ready) w_state_nx = S_HOLD;
      S_HOLD:   if (w_note_end) w_state_nx = (w_last && !w_loop) ? S_FINISH : S_FETCH;
      S_FINISH: w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
    if (stop && (r_state != S_IDLE)) begin
      w_state_nx = S_IDLE;
    end
  end

  // Pattern memory: writable only while idle, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en && (r_state == S_IDLE)) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Playback datapath: config capture, note latch, prescaler, beat count, step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= '0;
      r_tempo <= '0;
      r_step  <= '0;
      r_presc <= '0;
      r_beat  <= '0;
      r_dur   <= '0;
      r_note  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= (w_state_nx == S_ISSUE);
      r_busy  <= (w_state_nx != S_IDLE);
      r_done  <= (w_state_nx == S_FINISH);

      if (w_accept) begin
        r_len   <= len_i;
        r_tempo <= tempo_i;
        r_step  <= '0;
      end

      if ((r_state != S_IDLE) && (w_state_nx == S_IDLE)) begin
        r_note <= '0;
      end else if (r_state == S_FETCH) begin
        r_note <= w_entry[NOTE_W-1:0];
        r_dur  <= w_entry[ENT_W-1:NOTE_W];
      end

      if ((r_state == S_ISSUE) && (w_state_nx == S_HOLD)) begin
        r_presc <= '0;
        r_beat  <= '0;
      end else if (r_state == S_HOLD) begin
        // Prescaler never passes tempo, so an all-ones tempo cannot overflow
        if (w_beat) begin
          r_presc <= '0;
          r_beat  <= DUR_W'(r_beat + DUR_ONE);
        end else begin
          r_presc <= TICK_W'(r_presc + TICK_ONE);
        end
      end

      if ((r_state == S_HOLD) && (w_state_nx == S_FETCH)) begin
        r_step <= w_last ? '0 : IDX_W'(r_step + IDX_ONE);
      end
    end
  end

  assign note_valid = r_valid;
  assign note_code  = r_note;
  assign busy       = r_busy;
  assign step_idx   = r_step;
  assign done       = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus randomized
// patterns compared against a timing model built from the handshake formula.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] len_i;
  logic [15:0] tempo_i;
  logic       start;
  logic       stop;
  logic       loop_i;
  logic       note_valid;
  logic [5:0] note_code;
  logic       note_ready;
  logic       busy;
  logic [3:0] step_idx;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] m [16];
  int         exp_t [$];
  logic [5:0] exp_c [$];
  int         exp_done;
  int         hs_t [$];
  logic [5:0] hs_c [$];
  int         done_t [$];
  int         unstable;
  int         max_step;
  int         t0;
  bit         timed_out;

  note_sequencer #(.STEPS(16), .NOTE_W(6), .DUR_W(2), .TICK_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .len_i      (len_i),
    .tempo_i    (tempo_i),
    .start      (start),
    .stop       (stop),
`ifdef MUSIC_SEQ_LOOP_EN
    .loop_i     (loop_i),
`endif
    .note_valid (note_valid),
    .note_code  (note_code),
    .note_ready (note_ready),
    .busy       (busy),
    .step_idx   (step_idx),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic write_mem(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d; m[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_basic();
    write_mem(0, {2'd0, 6'd5});
    write_mem(1, {2'd1, 6'd9});
    write_mem(2, {2'd0, 6'd0});
  endtask

  // Reference: first handshake at start+2 (+stall), then each note holds for
  // (tempo+1)*(dur+1) cycles and the next handshake follows 2 cycles later.
  task automatic model(input int len, input int tempo, input int stall);
    int n, t, tl;
    exp_t.delete(); exp_c.delete();
    n = (len == 0) ? 16 : len;
    t = 2 + stall;
    for (int i = 0; i < n; i++) begin
      exp_t.push_back(t);
      exp_c.push_back(m[i][5:0]);
      tl = (tempo + 1) * (int'(m[i][7:6]) + 1);
      if (i == n - 1) exp_done = t + tl;
      else t = t + tl + 2;
    end
  endtask

  // Starts playback and records handshakes/done pulses relative to the start edge
  task automatic capture(input int len, input int tempo, input int stall, input int stop_at,
                         input int wr_at, input bit poke, input int budget);
    int n, stl, rel;
    bit pv, pr, stalled;
    logic [5:0] pc;
    hs_t.delete(); hs_c.delete(); done_t.delete();
    unstable = 0; timed_out = 1'b0; max_step = 0; stl = stall; n = 0;
    pv = 1'b0; pr = 1'b0; pc = '0;
    @(negedge clk);
    len_i = 4'(len); tempo_i = 16'(tempo); start = 1'b1; t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0; len_i = 4'($urandom); tempo_i = 16'($urandom);
    while (busy) begin
      rel = cyc + 1 - t0;
      if (done) done_t.push_back(cyc - t0);
      if (int'(step_idx) > max_step) max_step = int'(step_idx);
      if (pv && !pr && (!note_valid || note_code !== pc)) unstable++;
      stalled = note_valid && (stl > 0);
      note_ready = !stalled;
      if (stalled) stl--;
      if (note_valid && note_ready) begin
        hs_t.push_back(rel);
        hs_c.push_back(note_code);
      end
      stop  = (stop_at > 0) && (rel == stop_at);
      start = poke && note_valid;
      wr_en = (wr_at > 0) && (rel == wr_at);
      wr_addr = 4'd1; wr_data = {2'd0, 6'd33};
      pv = note_valid; pr = note_ready; pc = note_code;
      n++;
      if (n > budget) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
    end
    stop = 1'b0; start = 1'b0; wr_en = 1'b0; note_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len_i = '0; tempo_i = '0;
    start = 1'b0; stop = 1'b0; loop_i = 1'b0; note_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (note_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", note_valid); end
    n_cmp++; if (note_code !== 6'd0) begin n_err++; $display("FAIL reset_code got %0d want 0", note_code); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (step_idx !== 4'd0) begin n_err++; $display("FAIL reset_step got %0d want 0", step_idx); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    load_basic();
    model(3, 3, 0);
    capture(3, 3, 0, 0, 0, 1'b0, 200);
    n_cmp++; if (timed_out || hs_t.size() != exp_t.size()) begin n_err++; $display("FAIL basic_count got %0d want %0d to=%0b", hs_t.size(), exp_t.size(), timed_out); end
    for (int i = 0; i < exp_t.size() && i < hs_t.size(); i++) begin
      n_cmp++;
      if (hs_t[i] !== exp_t[i] || hs_c[i] !== exp_c[i]) begin
        n_err++; $display("FAIL basic_hs%0d got t=%0d c=%0d want t=%0d c=%0d", i, hs_t[i], hs_c[i], exp_t[i], exp_c[i]);
      end
    end
    n_cmp++; if (done_t.size() != 1 || done_t[0] != exp_done) begin n_err++; $display("FAIL basic_done got n=%0d want one at %0d", done_t.size(), exp_done); end
    n_cmp++; if (busy !== 1'b0 || note_code !== 6'd0) begin n_err++; $display("FAIL basic_idle got busy=%b code=%0d want 0/0", busy, note_code); end
  endtask

  task automatic test_backpressure();
    model(3, 3, 7);
    capture(3, 3, 7, 0, 0, 1'b0, 200);
    n_cmp++; if (timed_out || hs_t.size() != exp_t.size()) begin n_err++; $display("FAIL bp_count got %0d want %0d", hs_t.size(), exp_t.size()); end
    for (int i = 0; i < exp_t.size() && i < hs_t.size(); i++) begin
      n_cmp++;
      if (hs_t[i] !== exp_t[i] || hs_c[i] !== exp_c[i]) begin
        n_err++; $display("FAIL bp_hs%0d got t=%0d c=%0d want t=%0d c=%0d", i, hs_t[i], hs_c[i], exp_t[i], exp_c[i]);
      end
    end
    n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
    n_cmp++; if (done_t.size() != 1 || done_t[0] != exp_done) begin n_err++; $display("FAIL bp_done got n=%0d want one at %0d", done_t.size(), exp_done); end
  endtask

  task automatic test_stop();
    capture(3, 3, 0, 12, 0, 1'b0, 200);
    n_cmp++; if (timed_out || hs_c.size() != 2) begin n_err++; $display("FAIL stop_count got %0d want 2", hs_c.size()); end
    n_cmp++; if (hs_c.size() < 2 || hs_c[0] !== 6'd5 || hs_c[1] !== 6'd9) begin n_err++; $display("FAIL stop_codes got %0d entries want 5,9", hs_c.size()); end
    n_cmp++; if (busy !== 1'b0 || note_code !== 6'd0 || note_valid !== 1'b0) begin n_err++; $display("FAIL stop_idle got busy=%b code=%0d valid=%b want 0/0/0", busy, note_code, note_valid); end
    @(negedge clk);
    n_cmp++; if (done_t.size() != 0 || done !== 1'b0) begin n_err++; $display("FAIL stop_nodone got n=%0d done=%b want none", done_t.size(), done); end
    // stop beats a simultaneous start in idle
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_start got busy=%b want 0", busy); end
    model(3, 3, 0);
    capture(3, 3, 0, 0, 0, 1'b0, 200);
    n_cmp++; if (timed_out || hs_t.size() != exp_t.size()) begin n_err++; $display("FAIL stop_replay_count got %0d want %0d", hs_t.size(), exp_t.size()); end
    for (int i = 0; i < exp_t.size() && i < hs_t.size(); i++) begin
      n_cmp++;
      if (hs_t[i] !== exp_t[i] || hs_c[i] !== exp_c[i]) begin
        n_err++; $display("FAIL stop_replay_hs%0d got t=%0d c=%0d want t=%0d c=%0d", i, hs_t[i], hs_c[i], exp_t[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_write_busy();
    model(3, 3, 0);
    for (int r = 0; r < 2; r++) begin
      capture(3, 3, 0, 0, (r == 0) ? 4 : 0, 1'b0, 200);
      n_cmp++; if (timed_out || hs_c.size() != 3) begin n_err++; $display("FAIL wrbusy%0d_count got %0d want 3", r, hs_c.size()); end
      n_cmp++; if (hs_c.size() < 2 || hs_c[1] !== exp_c[1]) begin n_err++; $display("FAIL wrbusy%0d_step1 got %0d entries want code %0d", r, hs_c.size(), exp_c[1]); end
    end
  endtask

  task automatic test_len0();
    for (int i = 0; i < 16; i++) write_mem(i, 8'($urandom));
    model(0, 1, 0);
    capture(0, 1, 0, 0, 0, 1'b0, 400);
    n_cmp++; if (timed_out || hs_t.size() != 16) begin n_err++; $display("FAIL len0_count got %0d want 16", hs_t.size()); end
    for (int i = 0; i < exp_t.size() && i < hs_t.size(); i++) begin
      n_cmp++;
      if (hs_t[i] !== exp_t[i] || hs_c[i] !== exp_c[i]) begin
        n_err++; $display("FAIL len0_hs%0d got t=%0d c=%0d want t=%0d c=%0d", i, hs_t[i], hs_c[i], exp_t[i], exp_c[i]);
      end
    end
    n_cmp++; if (max_step != 15) begin n_err++; $display("FAIL len0_maxstep got %0d want 15", max_step); end
    n_cmp++; if (done_t.size() != 1 || done_t[0] != exp_done) begin n_err++; $display("FAIL len0_done got n=%0d want one at %0d", done_t.size(), exp_done); end
  endtask

  task automatic test_tempo0();
    write_mem(0, {2'd3, 6'd7});
    write_mem(1, {2'd0, 6'd8});
    capture(2, 0, 0, 0, 0, 1'b0, 100);
    n_cmp++; if (timed_out || hs_t.size() != 2) begin n_err++; $display("FAIL tempo0_count got %0d want 2", hs_t.size()); end
    n_cmp++; if (hs_t.size() < 2 || hs_t[1] - hs_t[0] != 6) begin n_err++; $display("FAIL tempo0_gap got %0d entries want gap 6", hs_t.size()); end
    n_cmp++; if (hs_c.size() < 2 || hs_c[0] !== 6'd7 || hs_c[1] !== 6'd8) begin n_err++; $display("FAIL tempo0_codes got %0d entries want 7,8", hs_c.size()); end
  endtask

  task automatic test_random();
    int len, tempo, stall, n;
    for (int it = 0; it < 6; it++) begin
      len   = (it == 0) ? 1 : int'($urandom_range(0, 15));
      tempo = int'($urandom_range(0, 3));
      stall = int'($urandom_range(0, 4));
      n = (len == 0) ? 16 : len;
      for (int i = 0; i < n; i++) write_mem(i, 8'($urandom));
      model(len, tempo, stall);
      capture(len, tempo, stall, 0, 0, 1'b1, 1000);
      n_cmp++; if (timed_out || hs_t.size() != exp_t.size()) begin n_err++; $display("FAIL rnd%0d_count got %0d want %0d", it, hs_t.size(), exp_t.size()); end
      for (int i = 0; i < exp_t.size() && i < hs_t.size(); i++) begin
        n_cmp++;
        if (hs_t[i] !== exp_t[i] || hs_c[i] !== exp_c[i]) begin
          n_err++; $display("FAIL rnd%0d_hs%0d got t=%0d c=%0d want t=%0d c=%0d", it, i, hs_t[i], hs_c[i], exp_t[i], exp_c[i]);
        end
      end
      n_cmp++; if (done_t.size() != 1 || done_t[0] != exp_done) begin n_err++; $display("FAIL rnd%0d_done got n=%0d want one at %0d", it, done_t.size(), exp_done); end
      n_cmp++; if (max_step > n - 1) begin n_err++; $display("FAIL rnd%0d_maxstep got %0d want <=%0d", it, max_step, n - 1); end
    end
  endtask

  task automatic test_async_reset();
    load_basic();
    @(negedge clk);
    len_i = 4'd3; tempo_i = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    n_cmp++; if (note_valid !== 1'b1 || note_code !== 6'd9) begin n_err++; $display("FAIL arst_pre got valid=%b code=%0d want 1/9", note_valid, note_code); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (note_valid !== 1'b0 || note_code !== 6'd0 || busy !== 1'b0 || step_idx !== 4'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL arst_clear got valid=%b code=%0d busy=%b step=%0d done=%b want all 0", note_valid, note_code, busy, step_idx, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model(3, 3, 0);
    capture(3, 3, 0, 0, 0, 1'b0, 200);
    n_cmp++; if (timed_out || hs_c.size() != 3) begin n_err++; $display("FAIL arst_replay_count got %0d want 3", hs_c.size()); end
    for (int i = 0; i < exp_c.size() && i < hs_c.size(); i++) begin
      n_cmp++;
      if (hs_t[i] !== exp_t[i] || hs_c[i] !== exp_c[i]) begin
        n_err++; $display("FAIL arst_replay_hs%0d got t=%0d c=%0d want t=%0d c=%0d", i, hs_t[i], hs_c[i], exp_t[i], exp_c[i]);
      end
    end
  endtask

`ifdef MUSIC_SEQ_LOOP_EN
  task automatic test_loop();
    int t;
    load_basic();
    loop_i = 1'b1;
    capture(2, 3, 0, 37, 0, 1'b0, 200);
    loop_i = 1'b0;
    exp_t.delete(); exp_c.delete();
    t = 2;
    for (int k = 0; k < 5; k++) begin
      exp_t.push_back(t);
      exp_c.push_back(m[k % 2][5:0]);
      t = t + 4 * (int'(m[k % 2][7:6]) + 1) + 2;
    end
    n_cmp++; if (timed_out || hs_t.size() != 5) begin n_err++; $display("FAIL loop_count got %0d want 5", hs_t.size()); end
    for (int i = 0; i < exp_t.size() && i < hs_t.size(); i++) begin
      n_cmp++;
      if (hs_t[i] !== exp_t[i] || hs_c[i] !== exp_c[i]) begin
        n_err++; $display("FAIL loop_hs%0d got t=%0d c=%0d want t=%0d c=%0d", i, hs_t[i], hs_c[i], exp_t[i], exp_c[i]);
      end
    end
    n_cmp++; if (done_t.size() != 0) begin n_err++; $display("FAIL loop_nodone got %0d pulses want 0", done_t.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stop();
    test_write_busy();
    test_len0();
    test_tempo0();
    test_random();
    test_async_reset();
`ifdef MUSIC_SEQ_LOOP_EN
    test_loop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got no finish want finish before %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Plays a programmed pattern of notes into the tone-generator datapath.
- Holds a small pattern memory that is written from the pin-level interface while idle.
- Steps through the pattern at a programmable tempo and hands each note code to the tone generator over a valid/ready handshake.
- Sits between the top-level pin decode and the tone/mixer datapath inside the music top.

Parameters:
- STEPS, 16, number of pattern entries (power of two, 2..64).
- NOTE_W, 6, note code width; code 0 = rest.
- DUR_W, 2, duration field width; a note lasts dur+1 beats.
- TICK_W, 16, tempo prescaler width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  pattern write strobe.
- wr_addr  in  $clog2(STEPS)  pattern write address.
- wr_data  in  DUR_W+NOTE_W  entry: {dur, note}.
- len_i  in  $clog2(STEPS)  pattern length; 0 means STEPS.
- tempo_i  in  TICK_W  beat period minus 1, in clk cycles.
- start  in  1  begin playback (level-sampled, acts on the first cycle seen in IDLE).
- stop  in  1  abort playback.
- note_valid  out  1  note_code is offered to the tone generator.
- note_code  out  NOTE_W  current note.
- note_ready  in  1  tone generator accepts note_code.
- busy  out  1  high in any state except IDLE.
- step_idx  out  $clog2(STEPS)  index of the current entry.
- done  out  1  one-cycle pulse at normal pattern completion.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. On reset: state=IDLE; note_valid, note_code, busy, step_idx and done are all 0; prescaler and beat counter are 0. Pattern memory is not reset (contents undefined).
- Writes: accepted only in IDLE; mem[wr_addr] <= wr_data. wr_en outside IDLE is ignored.
- len_i and tempo_i: captured into internal registers when start is accepted. Later changes have no effect until the next start.
- FSM states: IDLE, FETCH, ISSUE, HOLD, FINISH.
  - IDLE: when start=1 and stop=0: step_idx<=0, go to FETCH.
  - FETCH: latch the entry at step_idx into note_code and the dur register; go to ISSUE.
  - ISSUE: note_valid=1; note_code is held stable until handshake. On note_valid&&note_ready: clear prescaler and beat count, go to HOLD. Rest entries (code 0) are issued like any other note.
  - HOLD: note_valid=0. The prescaler counts 0..tempo_r and emits a beat on tempo_r, so the beat period is tempo_r+1 cycles; tempo 0 means a beat every cycle. After dur+1 beats: if step_idx==len-1, go to FINISH; else step_idx+1 and go to FETCH.
  - FINISH: done=1 for exactly one cycle; note_code<=0; go to IDLE.
- Latency:
  - note_valid first rises 2 cycles after the accepting start edge.
  - With note_ready held high, consecutive handshakes are (tempo+1)*(dur+1)+2 cycles apart.
- stop: from any non-IDLE state, the next state is IDLE. note_valid=0 and note_code=0 the following cycle, and no done pulse. stop wins over a simultaneous start. stop in IDLE has no effect.
- Other boundary cases:
  - start while busy is ignored.
  - len=1 plays entry 0 only.
  - step_idx never exceeds len-1.
  - The prescaler saturates cleanly at TICK_W all-ones (tempo_r = 2^TICK_W-1 is legal).
- Asynchronous reset mid-playback: immediate return to the reset values. Memory contents are kept.

Optional Feature:
- Macro MUSIC_SEQ_LOOP_EN.
- When defined: adds an input port loop_i (1 bit), captured at start. On completing the last step with loop_r=1, step_idx wraps to 0 and the FSM goes to FETCH with no done pulse and no FINISH state. With loop_r=0, behaviour is unchanged. Playback ends only via stop.
- When undefined: no loop_i port; playback always ends through FINISH.

Test Plan:
- Basic playback: write mem[0]={0,5}, mem[1]={1,9}, mem[2]={0,0}; len=3, tempo=3, note_ready=1, pulse start.
  - Handshakes with codes 5, 9, 0 at cycles t+2, t+8, t+18.
  - done pulses once, then busy=0 and note_code=0.
- Backpressure: same pattern, note_ready held low for 7 cycles on the first note.
  - note_valid=1 and note_code=5 are stable throughout; the first handshake moves to t+9.
  - HOLD timing after each handshake is unchanged.
- Stop mid-note: assert stop during the HOLD of step 1.
  - Next cycle: busy=0, note_code=0, no done pulse.
  - A new start replays from step 0.
- Write while busy: wr_en to address 1 with {0,33} during playback.
  - Step 1 still plays 9; after done, a replay plays 9 again.
- Edge cases:
  - len=0 with STEPS=16: 16 notes are issued, step_idx reaches 15, then done.
  - tempo=0, dur=3: handshakes 6 cycles apart.
- With MUSIC_SEQ_LOOP_EN, loop_i=1, len=2:
  - Codes 5, 9, 5, 9, ... with no done pulse until stop.
  - Reset mid-note clears all outputs asynchronously.
